mod107_mult_seq: RTL
====================

# mod107_mult_seq

Digit-serial sequencer for variable × variable multiplication modulo 107. It accepts two 7-bit residues over a valid/ready handshake. It walks the multiplier operand one 3-bit digit per clock, LSB first, through a digit × residue mod-107 product stage and a mod-107 accumulator, then returns the residue product over a second valid/ready handshake. It sits between the operand scheduler and the residue-number datapath, reusing one small digit-product stage across all digit positions.

## Interface
- `MOD`, 107: modulus; all results are in [0, MOD-1].
- `W`, 7: operand and result width.
- `DW`, 3: digit width.
- `ND`, 3: digits per multiplier operand (ND·DW ≥ W; upper digit bits zero-padded).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept an operand pair.
- `a`  in  W  multiplicand residue.
- `b`  in  W  multiplier residue (digit-serialised).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `z`  out  W  (a·b) mod MOD.
- `out_err`  out  1  an operand was ≥ MOD.
- `busy`  out  1  in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `a`, `b`, and err=(a≥MOD)||(b≥MOD); set acc=0, t=a mod MOD, cnt=0; go to RUN.
- RUN, each edge:
  - d = digit cnt of b.
  - acc ← (acc + d·t) mod MOD.
  - t ← (8·t) mod MOD.
  - cnt ← cnt+1.
  - After digit ND-1, go to DONE.
- Arithmetic:
  - d·t ≤ 7·106 = 742; acc + d·t ≤ 848.
  - Reduction is exact, by conditional subtraction of 4·MOD, 2·MOD, MOD (or equivalent). No intermediate value is truncated.
- DONE:
  - `out_valid`=1, `z`=acc, or 0 if err; `out_err`=err.
  - `z` and `out_err` are held stable until `out_valid`&&`out_ready`, then return to IDLE.
- `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE, with no queuing.
- Error case: an operand ≥ MOD gives `z`=0 and `out_err`=1, with the same latency as a normal operation.
- Reset mid-operation: at any state, reset aborts to IDLE; the in-flight operand is discarded and no result is emitted.

## Timing
- All outputs are registered.
- Reset values: `in_ready`=0, `out_valid`=0, `z`=0, `out_err`=0, `busy`=0.
- `in_ready` rises on the first edge after `rst` deasserts.
- Accept at edge k. Then `in_ready`=0 and `busy`=1 from k onward.
- `out_valid` rises at edge k+ND (k+3 by default).
- Result consumed at edge m: `out_valid`=0, `in_ready`=1, `busy`=0 from m.
- Next accept is possible at edge m+1. Minimum initiation interval is ND+2 cycles.
- Backpressure: with `out_ready` low, DONE holds indefinitely; outputs do not change.

## Configuration
- Macro: `MOD107_SEQ_EARLY_TERM_EN`.
- Defined:
  - RUN exits to DONE after the edge that processes the highest nonzero digit of b.
  - If b==0, exactly one RUN edge runs.
  - Latency is max(1, index of highest nonzero digit + 1) edges from accept to `out_valid`.
  - err cases still use the full ND.
- Undefined: latency is always ND. Results are identical in both builds.

## Test plan
- a=84, b=1, `out_ready`=1:
  - `z`=84, `out_err`=0.
  - `out_valid` at accept+3.
  - With the macro: at accept+1.
- a=84, b=106 (digits 2, 5, 1):
  - `z`=23, `out_err`=0.
  - Latency 3 in both builds.
- a=100, b=50 (digits 2, 6, 0):
  - `z`=78.
  - Latency 3 without the macro, 2 with it.
- a=106, b=106:
  - `z`=1.
  - Then hold `out_ready`=0 for 5 cycles: `out_valid`, `z`, `out_err` stable, `in_ready`=0, and a second `in_valid` is ignored.
  - Release `out_ready`: `in_ready`=1 on the next edge.
- a=110, b=5:
  - `z`=0, `out_err`=1, latency 3.
  - The following op a=5, b=7 yields `z`=35, `out_err`=0.
- Assert `rst` during RUN (cycle accept+1):
  - All outputs return to reset values asynchronously.
  - No `out_valid` pulse follows.
  - After release, `in_ready` rises next edge, and a=3, b=4 yields `z`=12.

Source files
------------

// File: rtl/mod107_mult_seq.sv
// Digit-serial (a*b) mod 107 sequencer. It walks b one DW-bit digit per clock, LSB first.
// The optional early termination is enabled with `define MOD107_SEQ_EARLY_TERM_EN.
module mod107_mult_seq #(
  parameter int unsigned MOD = 107,
  parameter int unsigned W   = 7,
  parameter int unsigned DW  = 3,
  parameter int unsigned ND  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         out_err,
  output logic         busy
);

  localparam int unsigned BW = ND * DW;
  localparam int unsigned AW = W + DW;
  localparam int unsigned CW = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    acc, t;
  logic [BW-1:0]   b_sh;
  logic [CW-1:0]   cnt;
  logic            err;
  logic [AW-1:0]   prod_sum;
  logic [W-1:0]    acc_nx, t_nx;
  logic            last;
  logic            accept;

  // Exact reduction of any value below 8*MOD, done by binary-weighted conditional subtraction.
  function automatic logic [W-1:0] red(input logic [AW-1:0] x);
    logic [AW-1:0] v;
    v = x;
    if (v >= AW'(4 * MOD)) v = v - AW'(4 * MOD);
    if (v >= AW'(2 * MOD)) v = v - AW'(2 * MOD);
    if (v >= AW'(MOD))     v = v - AW'(MOD);
    return v[W-1:0];
  endfunction

  assign accept = in_valid && in_ready;

  always_comb begin
    prod_sum = AW'(acc) + AW'(b_sh[DW-1:0]) * AW'(t);
    acc_nx   = red(prod_sum);
    t_nx     = red(AW'(t) << DW);
`ifdef MOD107_SEQ_EARLY_TERM_EN
    // b is shifted as it is consumed, so all-zero remaining digits mean the product is complete.
    last     = (cnt == CW'(ND - 1)) || (!err && (b_sh[BW-1:DW] == '0));
`else
    last     = (cnt == CW'(ND - 1));
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
      busy      <= (state_nx != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      t       <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      z       <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc  <= '0;
            t    <= (a >= W'(MOD)) ? (a - W'(MOD)) : a;
            b_sh <= BW'(b);
            cnt  <= '0;
            err  <= (a >= W'(MOD)) || (b >= W'(MOD));
          end
        end
        RUN: begin
          acc  <= acc_nx;
          t    <= t_nx;
          b_sh <= b_sh >> DW;
          cnt  <= cnt + 1'b1;
          if (last) begin
            z       <= err ? '0 : acc_nx;
            out_err <= err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
